// File: rtl/cache_bus_arbiter_if.sv
// One cache-bus channel: request beats flow master->slave and response beats
// flow slave->master. Each channel has its own cyc/ack handshake.
interface cache_bus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic                      reqack;
    logic                      respcyc;
    logic [BUS_DATA_WIDTH-1:0] resp;
    logic [BUS_TAG_WIDTH-1:0]  resptag;
    logic                      respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-port (ICache = port 0, DCache = port 1) round-robin arbiter onto one
// shared cache bus, with a single transaction outstanding at a time.
module cache_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    cache_bus_arbiter_if.slave        m0_if,
    cache_bus_arbiter_if.slave        m1_if,
    cache_bus_arbiter_if.master       bus_if,
    output logic [1:0]                grant_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         READ_BIT = 12;
    localparam logic [3:0] WB_LAST  = 4'(LINE_BEATS);
    localparam logic [3:0] RD_LAST  = 4'(LINE_BEATS - 1);

    state_t                     state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_grant_q, last_grant_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [3:0]                 cnt_q, cnt_d;

    logic                       own_reqcyc_s;
    logic [BUS_DATA_WIDTH-1:0]  own_req_s;
    logic [BUS_TAG_WIDTH-1:0]   own_reqtag_s;
    logic                       own_respack_s;
    logic                       req_fire_s;
    logic                       resp_match_s;
    logic                       resp_take_s;

    logic                       bus_reqcyc_s;
    logic [BUS_DATA_WIDTH-1:0]  bus_req_s;
    logic [BUS_TAG_WIDTH-1:0]   bus_reqtag_s;
    logic                       bus_respack_s;
    logic                       reqack_s;
    logic                       respcyc_s;
    logic [1:0]                 grant_s;

    assign own_reqcyc_s  = owner_q ? m1_if.reqcyc  : m0_if.reqcyc;
    assign own_req_s     = owner_q ? m1_if.req     : m0_if.req;
    assign own_reqtag_s  = owner_q ? m1_if.reqtag  : m0_if.reqtag;
    assign own_respack_s = owner_q ? m1_if.respack : m0_if.respack;

    assign req_fire_s   = (state_q == ST_REQ) && own_reqcyc_s && bus_if.reqack;
    // Beats tagged for someone else share the bus and must be ignored.
    assign resp_match_s = (state_q == ST_RESP) && bus_if.respcyc && (bus_if.resptag == tag_q);
    assign resp_take_s  = resp_match_s && own_respack_s;

    // State register with synchronous reset; last_grant=1 lets port 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tag_q        <= {BUS_TAG_WIDTH{1'b0}};
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: arbitration in IDLE, beat counting in REQ and RESP.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_if.reqcyc && m1_if.reqcyc) begin
                    owner_d      = ~last_grant_q;
                    last_grant_d = ~last_grant_q;
                    tag_d        = last_grant_q ? m0_if.reqtag : m1_if.reqtag;
                    cnt_d        = 4'd0;
                    state_d      = ST_REQ;
                end else if (m0_if.reqcyc) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    tag_d        = m0_if.reqtag;
                    cnt_d        = 4'd0;
                    state_d      = ST_REQ;
                end else if (m1_if.reqcyc) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    tag_d        = m1_if.reqtag;
                    cnt_d        = 4'd0;
                    state_d      = ST_REQ;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_fire_s) begin
                    if (tag_q[READ_BIT]) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == WB_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (resp_take_s) begin
                    if (cnt_q == RD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode: channels forward combinationally to the owner only.
    always_comb begin
        bus_reqcyc_s  = 1'b0;
        bus_req_s     = {BUS_DATA_WIDTH{1'b0}};
        bus_reqtag_s  = {BUS_TAG_WIDTH{1'b0}};
        bus_respack_s = 1'b0;
        reqack_s      = 1'b0;
        respcyc_s     = 1'b0;
        grant_s       = 2'b00;
        if (reset) begin
            grant_s = 2'b00;
        end else begin
            case (state_q)
                ST_REQ: begin
                    grant_s      = owner_q ? 2'b10 : 2'b01;
                    bus_reqcyc_s = own_reqcyc_s;
                    reqack_s     = own_reqcyc_s && bus_if.reqack;
                    if (own_reqcyc_s) begin
                        bus_req_s    = own_req_s;
                        bus_reqtag_s = own_reqtag_s;
                    end else begin
                        bus_req_s    = {BUS_DATA_WIDTH{1'b0}};
                        bus_reqtag_s = {BUS_TAG_WIDTH{1'b0}};
                    end
                end
                ST_RESP: begin
                    grant_s       = owner_q ? 2'b10 : 2'b01;
                    respcyc_s     = resp_match_s;
                    bus_respack_s = resp_take_s;
                end
                default: begin
                    grant_s = 2'b00;
                end
            endcase
        end
    end

    assign bus_if.reqcyc  = bus_reqcyc_s;
    assign bus_if.req     = bus_req_s;
    assign bus_if.reqtag  = bus_reqtag_s;
    assign bus_if.respack = bus_respack_s;

    assign m0_if.reqack   = reqack_s  && !owner_q;
    assign m1_if.reqack   = reqack_s  &&  owner_q;
    assign m0_if.respcyc  = respcyc_s && !owner_q;
    assign m1_if.respcyc  = respcyc_s &&  owner_q;
    assign m0_if.resp     = bus_if.resp;
    assign m1_if.resp     = bus_if.resp;
    assign m0_if.resptag  = bus_if.resptag;
    assign m1_if.resptag  = bus_if.resptag;

    assign grant_o = grant_s;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a transaction-level model predicts
// every output each cycle, and literal checks pin the key scenarios.
module tb_cache_bus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int LB = 8;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] grant;

    logic          drv_cyc     [2];
    logic [DW-1:0] drv_req     [2];
    logic [TW-1:0] drv_tag     [2];
    logic          drv_respack [2];
    logic          b_reqack;
    logic          b_respcyc;
    logic [DW-1:0] b_resp;
    logic [TW-1:0] b_resptag;

    int checks   = 0;
    int failures = 0;

    // transaction-level model
    bit          busy = 1'b0;
    bit          in_resp = 1'b0;
    int          owner = 0;
    int          last_won = 1;
    int          acks = 0;
    int          resps = 0;
    logic [TW-1:0] mtag = '0;

    // observation logs filled from DUT outputs
    int            m0_pulses = 0;
    logic [DW-1:0] bus_beats [$];
    logic [1:0]    grant_log [$];
    logic [1:0]    prev_grant = 2'b00;

    cache_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) m0_if ();
    cache_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) m1_if ();
    cache_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

    assign m0_if.reqcyc    = drv_cyc[0];
    assign m0_if.req       = drv_req[0];
    assign m0_if.reqtag    = drv_tag[0];
    assign m0_if.respack   = drv_respack[0];
    assign m1_if.reqcyc    = drv_cyc[1];
    assign m1_if.req       = drv_req[1];
    assign m1_if.reqtag    = drv_tag[1];
    assign m1_if.respack   = drv_respack[1];
    assign bus_if.reqack   = b_reqack;
    assign bus_if.respcyc  = b_respcyc;
    assign bus_if.resp     = b_resp;
    assign bus_if.resptag  = b_resptag;

    cache_bus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .LINE_BEATS     (LB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_if   (m0_if),
        .m1_if   (m1_if),
        .bus_if  (bus_if),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, then advance the model.
    initial begin
        logic [1:0]    e_grant, e_rack, e_rcyc;
        logic          e_bcyc, e_back, match;
        logic [DW-1:0] e_breq;
        logic [TW-1:0] e_btag;
        forever begin
            @(negedge clk);
            e_grant = 2'b00; e_rack = 2'b00; e_rcyc = 2'b00;
            e_bcyc = 1'b0; e_back = 1'b0; e_breq = '0; e_btag = '0; match = 1'b0;
            if (!reset && busy) begin
                e_grant = (owner == 1) ? 2'b10 : 2'b01;
                if (!in_resp) begin
                    if (drv_cyc[owner]) begin
                        e_bcyc = 1'b1;
                        e_breq = drv_req[owner];
                        e_btag = drv_tag[owner];
                        e_rack[owner] = b_reqack;
                    end
                end else begin
                    match = b_respcyc && (b_resptag == mtag);
                    e_rcyc[owner] = match;
                    e_back = match && drv_respack[owner];
                end
            end
            chk("grant",       64'(grant),          64'(e_grant));
            chk("bus_reqcyc",  64'(bus_if.reqcyc),  64'(e_bcyc));
            chk("bus_req",     bus_if.req,          e_breq);
            chk("bus_reqtag",  64'(bus_if.reqtag),  64'(e_btag));
            chk("bus_respack", 64'(bus_if.respack), 64'(e_back));
            chk("m0_reqack",   64'(m0_if.reqack),   64'(e_rack[0]));
            chk("m1_reqack",   64'(m1_if.reqack),   64'(e_rack[1]));
            chk("m0_respcyc",  64'(m0_if.respcyc),  64'(e_rcyc[0]));
            chk("m1_respcyc",  64'(m1_if.respcyc),  64'(e_rcyc[1]));
            chk("m0_resp",     m0_if.resp,          b_resp);
            chk("m1_resptag",  64'(m1_if.resptag),  64'(b_resptag));

            if (m0_if.respcyc === 1'b1) m0_pulses++;
            if (bus_if.reqcyc === 1'b1 && b_reqack) bus_beats.push_back(bus_if.req);
            if (prev_grant == 2'b00 && grant != 2'b00) grant_log.push_back(grant);
            prev_grant = grant;

            if (reset) begin
                busy = 1'b0; in_resp = 1'b0; last_won = 1;
            end else if (!busy) begin
                if (drv_cyc[0] || drv_cyc[1]) begin
                    if (drv_cyc[0] && drv_cyc[1]) owner = 1 - last_won;
                    else owner = drv_cyc[0] ? 0 : 1;
                    last_won = owner;
                    busy = 1'b1; in_resp = 1'b0;
                    mtag = drv_tag[owner]; acks = 0; resps = 0;
                end
            end else if (!in_resp) begin
                if (drv_cyc[owner] && b_reqack) begin
                    acks++;
                    if (mtag[12]) in_resp = 1'b1;
                    else if (acks == LB + 1) busy = 1'b0;
                end
            end else begin
                if (b_respcyc && b_resptag == mtag && drv_respack[owner]) begin
                    resps++;
                    if (resps == LB) busy = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            drv_cyc[p] = 1'b0; drv_req[p] = '0; drv_tag[p] = '0; drv_respack[p] = 1'b0;
        end
        b_reqack = 1'b0; b_respcyc = 1'b0; b_resp = '0; b_resptag = '0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_grant", 64'(grant), 64'(2'b00));

        // Contest: both ports ask for a read with the same tag.
        step();
        drv_cyc[0] = 1'b1; drv_req[0] = 64'hA000; drv_tag[0] = 13'h1103;
        drv_cyc[1] = 1'b1; drv_req[1] = 64'hB000; drv_tag[1] = 13'h1103;
        drv_respack[0] = 1'b1; drv_respack[1] = 1'b1;
        @(negedge clk);
        chk("idle_no_bus_req", 64'(bus_if.reqcyc), 64'(1'b0));
        step();
        @(negedge clk);
        chk("contest_grant", 64'(grant), 64'(2'b01));
        step();
        b_reqack = 1'b1;
        @(negedge clk);
        chk("owner_reqack", 64'(m0_if.reqack), 64'(1'b1));
        chk("nonowner_reqack", 64'(m1_if.reqack), 64'(1'b0));
        step();

        // Read response with a foreign beat interleaved after three beats.
        drv_cyc[0] = 1'b0; b_reqack = 1'b0;
        drv_tag[1] = 13'h0103; drv_req[1] = 64'hC0DE_0000;
        m0_pulses = 0;
        for (int i = 0; i < LB + 1; i++) begin
            b_respcyc = 1'b1;
            b_resp    = 64'h1000 + 64'(i);
            b_resptag = (i == 3) ? 13'h0000 : 13'h1103;
            if (i == 3) begin
                @(negedge clk);
                chk("foreign_not_fwd", 64'(m0_if.respcyc), 64'(1'b0));
                chk("foreign_not_ack", 64'(bus_if.respack), 64'(1'b0));
            end
            step();
        end
        b_respcyc = 1'b0; b_resptag = '0;
        chk("m0_resp_pulses", 64'(m0_pulses), 64'(8));
        @(negedge clk);
        chk("read_done_idle", 64'(grant), 64'(2'b00));
        step();

        // Port 1 write-back, bus withholds ack on beats 3 and 6.
        bus_beats.delete();
        for (int k = 0; k < LB + 1; k++) begin
            drv_req[1] = 64'hC0DE_0000 + 64'(k);
            if (k == 0) begin
                b_reqack = 1'b1;
                @(negedge clk);
                chk("port1_next", 64'(grant), 64'(2'b10));
            end
            if (k == 2 || k == 5) begin
                b_reqack = 1'b0; step();
            end
            if (k == 7) begin
                drv_cyc[1] = 1'b0; b_reqack = 1'b1; step();
                drv_cyc[1] = 1'b1;
            end
            b_reqack = 1'b1;
            step();
        end
        drv_cyc[1] = 1'b0; b_reqack = 1'b0;
        @(negedge clk);
        chk("wb_idle", 64'(grant), 64'(2'b00));
        chk("wb_beat_count", 64'(bus_beats.size()), 64'(LB + 1));
        for (int k = 0; k < bus_beats.size(); k++)
            chk("wb_beat", bus_beats[k], 64'hC0DE_0000 + 64'(k));

        // Continuous write-backs on both ports must alternate.
        step();
        grant_log.delete();
        drv_cyc[0] = 1'b1; drv_tag[0] = 13'h0103; drv_req[0] = 64'h5000;
        drv_cyc[1] = 1'b1; drv_tag[1] = 13'h0103; drv_req[1] = 64'h6000;
        b_reqack = 1'b1;
        for (int n = 0; n < 60 && grant_log.size() < 4; n++) step();
        drv_cyc[0] = 1'b0;
        for (int n = 0; n < 20 && grant !== 2'b00; n++) step();
        drv_cyc[1] = 1'b0; b_reqack = 1'b0;
        chk("rr_drained", 64'(grant), 64'(2'b00));
        chk("rr_count", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() >= 4) begin
            chk("rr_0", 64'(grant_log[0]), 64'(2'b01));
            chk("rr_1", 64'(grant_log[1]), 64'(2'b10));
            chk("rr_2", 64'(grant_log[2]), 64'(2'b01));
            chk("rr_3", 64'(grant_log[3]), 64'(2'b10));
        end

        // Port 0 read, reset after three response beats.
        drv_cyc[0] = 1'b1; drv_tag[0] = 13'h1103; drv_req[0] = 64'hA100;
        b_reqack = 1'b1;
        step(); step();
        drv_cyc[0] = 1'b0; b_reqack = 1'b0;
        b_respcyc = 1'b1; b_resptag = 13'h1103;
        for (int i = 0; i < 3; i++) begin
            b_resp = 64'h2000 + 64'(i);
            step();
        end
        reset = 1'b1;
        drv_cyc[0] = 1'b1; drv_cyc[1] = 1'b1;
        drv_tag[1] = 13'h1103;
        @(negedge clk);
        chk("in_reset_respcyc", 64'(m0_if.respcyc), 64'(1'b0));
        chk("in_reset_grant", 64'(grant), 64'(2'b00));
        step();
        reset = 1'b0;
        b_respcyc = 1'b0; b_resp = '0; b_resptag = '0; b_reqack = 1'b0;
        @(negedge clk);
        chk("after_reset_grant", 64'(grant), 64'(2'b00));
        chk("after_reset_bus", 64'(bus_if.reqcyc), 64'(1'b0));
        step();
        @(negedge clk);
        chk("reset_contest", 64'(grant), 64'(2'b01));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BUS_DATA_WIDTH, 64, bus data width.
- BUS_TAG_WIDTH, 13, bus tag width.
- LINE_BEATS, 8, data beats per cache line.
REQ-002 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-003 Ports SHALL be (name, direction, width, meaning). N = 0 is the ICache port and N = 1 is the DCache port; each mN_ line applies to both ports.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mN_reqcyc  in  1  requester N has a request beat valid.
- mN_req  in  BUS_DATA_WIDTH  request address or data beat.
- mN_reqtag  in  BUS_TAG_WIDTH  request tag; bit 12 = 1 means read, bit 12 = 0 means write-back.
- mN_reqack  out  1  beat accepted.
- mN_respcyc  out  1  response beat valid.
- mN_resp  out  BUS_DATA_WIDTH  response data.
- mN_resptag  out  BUS_TAG_WIDTH  response tag.
- mN_respack  in  1  response beat consumed.
- bus_reqcyc, bus_req, bus_reqtag  out  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  shared request channel.
- bus_reqack  in  1  bus accepted the request beat.
- bus_respcyc, bus_resp, bus_resptag  in  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  shared response channel.
- bus_respack  out  1  response beat consumed.
- grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ and RESP, plus an owner register, a last_grant register, a latched tag register, and a 4-bit beat counter.
REQ-005 In IDLE:
- bus_reqcyc SHALL be 0.
- If exactly one mN_reqcyc is 1, the FSM SHALL set owner = N, latch mN_reqtag, clear the counter and go to REQ on the next edge.
REQ-006 If both requests are 1 in IDLE, the arbiter SHALL grant the port not equal to last_grant (round-robin), then set last_grant = owner.
REQ-007 The grant-to-bus latency SHALL be exactly one cycle: the request is sampled in IDLE and bus_reqcyc is driven in the following cycle.
REQ-008 In REQ, the request channel SHALL forward combinationally:
- bus_reqcyc, bus_req and bus_reqtag from the owner's request inputs.
- bus_reqack to the owner's reqack.
- The non-owner's reqack SHALL be held at 0.
REQ-009 In REQ, the counter SHALL increment on each cycle with bus_reqcyc and bus_reqack both 1.
REQ-010 A read (latched tag bit 12 = 1) SHALL leave REQ for RESP on its first acked beat, and the counter SHALL be cleared.
REQ-011 A write-back (latched tag bit 12 = 0) SHALL return to IDLE on its (LINE_BEATS+1)-th acked beat (one address beat plus 8 data beats).
REQ-012 If the owner deasserts reqcyc during REQ, the arbiter SHALL remain in REQ and keep the grant; there is no abort.
REQ-013 In RESP:
- A response beat matches when bus_respcyc = 1 and bus_resptag equals the latched tag.
- The owner's respcyc SHALL be 1 only on a matching beat.
- bus_respack SHALL equal the owner's respack on a matching beat, and 0 otherwise.
REQ-014 Non-matching response beats SHALL be neither forwarded nor acknowledged.
REQ-015 In RESP, the counter SHALL increment on each cycle where the beat matches and the owner's respack is 1. On the LINE_BEATS-th such beat the FSM SHALL return to IDLE.
REQ-016 mN_resp and mN_resptag SHALL carry bus_resp and bus_resptag unconditionally. The non-owner's respcyc SHALL always be 0.
REQ-017 grant SHALL be one-hot of owner in REQ and RESP, and 00 in IDLE.
REQ-018 The arbiter SHALL support only one outstanding transaction; a new grant SHALL NOT be issued before the return to IDLE.
REQ-019 A request arriving on the IDLE-return edge SHALL be arbitrated in IDLE on the next cycle, giving a minimum of one idle cycle between transactions.
REQ-020 bus_req and bus_reqtag SHALL be 0 whenever bus_reqcyc is 0.

Reset
REQ-021 Synchronous reset SHALL set:
- state = IDLE, owner = 0, counter = 0, latched tag = 0.
- last_grant = 1, so that port 0 wins the first contest.
REQ-022 During reset and in the cycle after it, all outputs SHALL be 0: grant, bus_reqcyc, bus_req, bus_reqtag, bus_respack, mN_reqack and mN_respcyc.
REQ-023 Reset asserted mid-transaction (REQ or RESP) SHALL abandon the transaction with no further beats forwarded. The bench SHALL also reset the bus model.

Verification
REQ-024 Bench SHALL cover:
- Reset, then both ports raise reqcyc with tag 13'h1103 -> grant = 01 one cycle later; port 1 receives no reqack.
- Port 0 read (tag 13'h1103): one acked address beat, then 8 matching response beats with respack -> exactly 8 m0_respcyc pulses, grant back to 00, and port 1 is granted next.
- Port 1 write-back (tag 13'h0103): 9 beats, bus_reqack withheld on beats 3 and 6 -> bus_req sequence identical to m1_req beats, and IDLE after the 9th ack.
- RESP with an interleaved beat tagged 13'h0000 -> not forwarded, bus_respack = 0, counter unchanged.
- Continuous requests on both ports -> grants alternate 01, 10, 01, 10.
- Reset asserted in RESP after 3 beats -> next cycle all outputs 0 and state IDLE; port 0 wins the next contest.
